// File: rtl/fir_ser_pkg.sv
// Shared types and constants for the FIR output serializer.
package fir_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } ser_state_t;

    localparam int DATA_W_DEF = 11;
    localparam int BYTE_W_DEF = 8;

    // Number of sign bits needed to pad the upper word bits out to a full byte.
    function automatic int sign_pad(input int data_w, input int byte_w);
        return 2 * byte_w - data_w;
    endfunction

endpackage

// File: rtl/fir_out_serializer_if.sv
// Result-in / byte-out signal bundle; master is the serializer, slave the FIR source plus byte sink.
// Adds m_parity when FIR_SER_PARITY_EN is defined.
interface fir_out_serializer_if #(
    parameter int DATA_W = 11,
    parameter int BYTE_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
`ifdef FIR_SER_PARITY_EN
    logic              m_parity;
`endif

    modport master (
        input  s_valid, s_data, m_ready,
`ifdef FIR_SER_PARITY_EN
        output m_parity,
`endif
        output m_data, m_valid, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
`ifdef FIR_SER_PARITY_EN
        input  m_parity,
`endif
        input  m_data, m_valid, m_last
    );
endinterface

// File: rtl/fir_ser_fifo.sv
// Sync FIFO with fall-through head; 0-cycle read of head, push on full is taken only with a same-edge pop.
// No backpressure: a push the FIFO cannot hold is ignored and left to the caller to flag.
module fir_ser_fifo #(
    parameter  int W     = 11,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// FIR result -> FIFO -> two-byte (low, sign-extended high) valid/ready stream; LO byte valid 1 cycle after an idle push.
// Stalls hold the byte stable; a full FIFO drops new results and sets sticky overflow. FIR_SER_PARITY_EN adds m_parity.
module fir_out_serializer
    import fir_ser_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int BYTE_W     = BYTE_W_DEF,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fir_out_serializer_if.master  bus,
    input  logic                  clr_ovf,
    output logic                  overflow,
    output logic [LW-1:0]         level
);
    localparam int PAD = sign_pad(DATA_W, BYTE_W);

    ser_state_t             state, state_nxt;
    logic [DATA_W-1:0]      fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   load_lo;
    logic                   load_hi;
    logic                   go_idle;
    logic                   hs;
    logic [DATA_W-BYTE_W-1:0] tx_hi;
    logic [BYTE_W-1:0]      hi_byte;
    logic [BYTE_W-1:0]      byte_nxt;
    logic [BYTE_W-1:0]      data_q;
    logic                   valid_q;
    logic                   last_q;

    fir_ser_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.s_valid),
        .pop   (pop),
        .din   (bus.s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign hs       = valid_q && bus.m_ready;
    assign hi_byte  = {{PAD{tx_hi[DATA_W-BYTE_W-1]}}, tx_hi};
    assign byte_nxt = load_lo ? fifo_dout[BYTE_W-1:0] : hi_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_lo   = 1'b0;
        load_hi   = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop       = 1'b1;
                load_lo   = 1'b1;
                state_nxt = LO;
            end
            LO: if (hs) begin
                load_hi   = 1'b1;
                state_nxt = HI;
            end
            HI: if (hs) begin
                // Back-to-back words: reload straight from the FIFO head, no idle bubble.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_lo   = 1'b1;
                    state_nxt = LO;
                end else begin
                    go_idle   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_hi   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (load_lo) tx_hi <= fifo_dout[DATA_W-1:BYTE_W];
            if (load_lo || load_hi) begin
                data_q  <= byte_nxt;
                valid_q <= 1'b1;
                last_q  <= load_hi;
            end else if (go_idle) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  overflow <= 1'b0;
        else if (bus.s_valid && fifo_full && !pop)   overflow <= 1'b1;
        else if (clr_ovf)                            overflow <= 1'b0;
    end

`ifdef FIR_SER_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  par_q <= 1'b0;
        else if (load_lo || load_hi) par_q <= ^byte_nxt;
    end
    assign bus.m_parity = par_q;
`endif

    assign bus.m_data  = data_q;
    assign bus.m_valid = valid_q;
    assign bus.m_last  = last_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed bench for fir_out_serializer: vector table of single words plus stall, burst, overflow and reset sequences.
module tb_fir_out_serializer;
    localparam int DW = 11;
    localparam int BW = 8;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          overflow;
    logic [LW-1:0] level;

    fir_out_serializer_if #(.DATA_W(DW), .BYTE_W(BW)) bus ();

    fir_out_serializer #(.DATA_W(DW), .BYTE_W(BW), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr_ovf  (clr_ovf),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic par_s;
`ifdef FIR_SER_PARITY_EN
    assign par_s = bus.m_parity;
`else
    assign par_s = 1'b0;
`endif

    // Byte log: {parity, last, data}; accepted bytes are seen at the negedge before the accepting edge.
    logic [9:0] rxq[$];
    int         rxc[$];
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            rxq.push_back({par_s, bus.m_last, bus.m_data});
            rxc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        for (k = 0; k < budget && rxq.size() < n; k++) @(posedge clk);
        #1;
        chk("byte_wait", (rxq.size() >= n) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [BW-1:0] lo;
        logic [BW-1:0] hi;
        logic          plo;
        logic          phi;
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        vt[0] = '{11'h5A3, 8'hA3, 8'hFD, 1'b0, 1'b1};
        vt[1] = '{11'h07F, 8'h7F, 8'h00, 1'b1, 1'b0};
        vt[2] = '{11'h400, 8'h00, 8'hFC, 1'b0, 1'b0};
        vt[3] = '{11'h3FF, 8'hFF, 8'h03, 1'b0, 1'b0};
        vt[4] = '{11'h155, 8'h55, 8'h01, 1'b0, 1'b1};
        vt[5] = '{11'h7FF, 8'hFF, 8'hFF, 1'b0, 1'b0};

        #12;
        chk("rst_outputs", {bus.m_valid, bus.m_last, bus.m_data, overflow, level}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Single words through an idle block, with latency check.
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rxq.delete();
            rxc.delete();
            bus.s_valid = 1'b1;
            bus.s_data  = vt[i].d;
            @(posedge clk);
            #1;
            bus.s_valid = 1'b0;
            @(negedge clk);
            chk("lat_not_yet", bus.m_valid, 0);
            @(negedge clk);
            chk("lat_lo_byte", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, 1'b0, vt[i].lo});
            @(posedge clk);
            #1;
            wait_bytes(2, 10);
            chk("vec_lo", rxq[0][8:0], {1'b0, vt[i].lo});
            chk("vec_hi", rxq[1][8:0], {1'b1, vt[i].hi});
`ifdef FIR_SER_PARITY_EN
            chk("vec_par_lo", rxq[0][9], vt[i].plo);
            chk("vec_par_hi", rxq[1][9], vt[i].phi);
`endif
            tick(2);
            chk("vec_idle", bus.m_valid, 0);
        end

        // Backpressure holds the low byte stable.
        bus.m_ready = 1'b0;
        strobe(11'h07F);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, 1'b0, 8'h7F});
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_hi", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, 1'b1, 8'h00});
        @(posedge clk);
        @(negedge clk);
        chk("stall_done", bus.m_valid, 0);
        @(posedge clk);
        #1;

        // Burst of 5 back-to-back strobes, no bubbles.
        rxq.delete();
        rxc.delete();
        for (int i = 1; i <= 5; i++) strobe(DW'(i));
        wait_bytes(10, 40);
        chk("burst_count", rxq.size(), 10);
        for (int k = 0; k < 10; k++)
            chk("burst_byte", rxq[k][8:0], (k % 2 == 0) ? {1'b0, 8'(k / 2 + 1)} : {1'b1, 8'h00});
        chk("burst_nobubble", rxc[9] - rxc[0], 9);
        chk("burst_ovf", overflow, 0);

        // Overflow: 6 strobes into a stalled block, 6th is lost.
        tick(3);
        bus.m_ready = 1'b0;
        rxq.delete();
        rxc.delete();
        for (int i = 0; i < 6; i++) strobe(DW'(11'h021 + i));
        @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 4);
        @(posedge clk);
        #1;
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_clear", overflow, 0);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        tick(25);
        chk("ovf_drain_count", rxq.size(), 10);
        for (int k = 0; k < 5; k++)
            chk("ovf_drain_lo", rxq[2 * k][7:0], 8'h21 + 8'(k));

        // Full FIFO: push on the same edge as a HI-handshake pop is accepted.
        bus.m_ready = 1'b0;
        rxq.delete();
        rxc.delete();
        for (int i = 0; i < 5; i++) strobe(DW'(11'h031 + i));
        @(negedge clk);
        chk("full_level", level, 4);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        tick(1);
        bus.s_valid = 1'b1;
        bus.s_data  = 11'h036;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_level", level, 4);
        chk("pushpop_ovf", overflow, 0);
        @(posedge clk);
        #1;
        tick(30);
        chk("pushpop_count", rxq.size(), 12);
        chk("pushpop_first", rxq[0][7:0], 8'h31);
        chk("pushpop_last", rxq[10][7:0], 8'h36);

        // Asynchronous reset in the middle of a HI beat.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) strobe(DW'(11'h041 + i));
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_hi", {bus.m_valid, bus.m_last, overflow}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bus.m_valid, bus.m_last, bus.m_data, overflow, level}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        tick(5);
        chk("post_rst_idle", {bus.m_valid, level}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
